// File: rtl/imem_pkg.sv
// Shared definitions for the pipelined instruction ROM: image depth,
// default word width, instruction type and the program image itself.
package imem_pkg;

    localparam int IMG_DEPTH      = 14;
    localparam int DEFAULT_DATA_W = 32;
    localparam int IMG_IDX_W      = $clog2(IMG_DEPTH);

    typedef logic [DEFAULT_DATA_W-1:0] instr_t;

    // Program image, word 0 at byte address 0.
    localparam instr_t IMEM_IMAGE [0:IMG_DEPTH-1] = '{
        32'hE590_1000, 32'hE590_2001, 32'hE590_3002, 32'hE590_4003,
        32'hE082_5001, 32'hE041_6004, 32'hE590_7003, 32'hE590_7003,
        32'hEA00_0001, 32'hE590_1001, 32'hE590_1001, 32'hE590_F000,
        32'hE590_1002, 32'hE590_1002
    };

endpackage

// File: rtl/imem_rom_pipe_rsp_fifo2.sv
// Two-entry response FIFO. The head entry is read straight from its storage
// register, so consumers see a stable word for as long as it is not popped.
// Callers never push when full or pop when empty.
module rsp_fifo2 #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] mem [0:1];
    logic         wr_ptr;
    logic         rd_ptr;

    // Storage, pointers and occupancy; reset empties the buffer and zeroes the head.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/imem_rom_pipe.sv
// Pipelined instruction ROM: byte address in, instruction word out one cycle
// after acceptance through a 2-entry response buffer. Misaligned and
// out-of-range fetches return DEFAULT_WORD with rsp_err set. Saturating
// counters track delivered and erroneous responses for debug.
module imem_rom_pipe
    import imem_pkg::*;
#(
    parameter int                DATA_W       = DEFAULT_DATA_W,
    parameter int                ADDR_W       = 32,
    parameter int                DEPTH        = 14,
    parameter logic [DATA_W-1:0] DEFAULT_WORD = DATA_W'(32'hFFFF_FFFF),
    parameter int                CNT_W        = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_adr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [CNT_W-1:0]  fetch_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    if (DEPTH > IMG_DEPTH || DEPTH < 1) begin : g_depth_chk
        $error("imem_rom_pipe: DEPTH must be in 1..IMG_DEPTH");
    end

    logic [ADDR_W-1:0] idx;
    logic              misaligned;
    logic              out_of_range;
    logic              lookup_err;
    logic [DATA_W-1:0] lookup_data;
    logic              push;
    logic              pop;
    logic [DATA_W:0]   head;
    logic [1:0]        count;

    // The full word index is compared against DEPTH so high address bits never alias.
    assign idx          = req_adr >> 2;
    assign misaligned   = |req_adr[1:0];
    assign out_of_range = idx >= ADDR_W'(DEPTH);

    // ROM lookup; faulting fetches substitute DEFAULT_WORD.
    always_comb begin
        lookup_err  = 1'b1;
        lookup_data = DEFAULT_WORD;
        if (!misaligned && !out_of_range) begin
            lookup_err  = 1'b0;
            lookup_data = DATA_W'(IMEM_IMAGE[idx[IMG_IDX_W-1:0]]);
        end
    end

    // Ready depends only on registered occupancy, never on rsp_ready.
    assign req_ready = (count < 2'd2);
    assign rsp_valid = (count != 2'd0);
    assign push      = req_valid & req_ready;
    assign pop       = rsp_valid & rsp_ready;

    rsp_fifo2 #(
        .W (DATA_W + 1)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({lookup_err, lookup_data}),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    assign rsp_err  = head[DATA_W];
    assign rsp_data = head[DATA_W-1:0];

    // Saturating debug counters, advanced on each delivered response.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt <= '0;
            err_cnt   <= '0;
        end else if (pop) begin
            if (fetch_cnt != '1) begin
                fetch_cnt <= fetch_cnt + 1'b1;
            end
            if (rsp_err && err_cnt != '1) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imem_rom_pipe.sv
// Scoreboard bench for imem_rom_pipe: stimulus pushes expected {err,data}
// into a queue on acceptance, a negedge monitor pops and compares on every
// delivered response.
module tb_imem_rom_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_adr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [15:0] fetch_cnt;
    logic [15:0] err_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [32:0] sb [$];

    logic [31:0] img [0:13] = '{
        32'hE590_1000, 32'hE590_2001, 32'hE590_3002, 32'hE590_4003,
        32'hE082_5001, 32'hE041_6004, 32'hE590_7003, 32'hE590_7003,
        32'hEA00_0001, 32'hE590_1001, 32'hE590_1001, 32'hE590_F000,
        32'hE590_1002, 32'hE590_1002
    };

    imem_rom_pipe dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_adr   (req_adr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .fetch_cnt (fetch_cnt),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Present one request and hold it until accepted; expected word is queued.
    task automatic issue(input logic [31:0] adr, input logic [31:0] d, input logic e);
        int waited = 0;
        req_valid = 1'b1;
        req_adr   = adr;
        while (req_ready !== 1'b1 && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (req_ready !== 1'b1) begin
            fail_now("issue_timeout");
            req_valid = 1'b0;
            return;
        end
        sb.push_back({e, d});
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int waited = 0;
        rsp_ready = 1'b1;
        while (rsp_valid === 1'b1 && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (rsp_valid === 1'b1) fail_now("drain_timeout");
        chk("sb_empty", 64'(sb.size()), 64'd0);
    endtask

    // Monitor: compare every delivered response against the scoreboard head.
    always @(negedge clk) begin
        if (reset === 1'b0 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rsp: got %h err %b expected none", rsp_data, rsp_err);
            end else begin
                chk("rsp_word", {31'd0, rsp_err, rsp_data}, {31'd0, sb.pop_front()});
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_adr   = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state.
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);
        chk("rst_rsp_err", 64'(rsp_err), 64'd0);
        chk("rst_fetch_cnt", 64'(fetch_cnt), 64'd0);
        chk("rst_err_cnt", 64'(err_cnt), 64'd0);

        // Single fetch, latency one.
        issue(32'h0, 32'hE590_1000, 1'b0);
        chk("lat1_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("lat1_rsp_data", 64'(rsp_data), 64'hE590_1000);
        drain();
        chk("lat1_fetch_cnt", 64'(fetch_cnt), 64'd1);

        // Back-to-back stream over the whole image.
        for (int i = 0; i < 14; i++) begin
            issue(32'(i * 4), img[i], 1'b0);
            chk("stream_valid", 64'(rsp_valid), 64'd1);
            chk("stream_ready", 64'(req_ready), 64'd1);
        end
        @(posedge clk); #1;
        chk("stream_no_tail", 64'(rsp_valid), 64'd0);
        drain();
        chk("stream_fetch_cnt", 64'(fetch_cnt), 64'd15);

        // Faulting fetches.
        issue(32'h0000_0038, 32'hFFFF_FFFF, 1'b1);
        issue(32'h0000_0002, 32'hFFFF_FFFF, 1'b1);
        issue(32'h1000_0000, 32'hFFFF_FFFF, 1'b1);
        drain();
        chk("err_err_cnt", 64'(err_cnt), 64'd3);
        chk("err_fetch_cnt", 64'(fetch_cnt), 64'd18);

        // Backpressure: fill both entries, third request stalls.
        rsp_ready = 1'b0;
        issue(32'h04, 32'hE590_2001, 1'b0);
        issue(32'h08, 32'hE590_3002, 1'b0);
        chk("full_req_ready", 64'(req_ready), 64'd0);
        req_valid = 1'b1;
        req_adr   = 32'h38;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("stall_req_ready", 64'(req_ready), 64'd0);
            chk("stall_data", {31'd0, rsp_err, rsp_data}, {31'd0, 1'b0, 32'hE590_2001});
        end
        req_adr   = 32'h0C;
        rsp_ready = 1'b1;
        issue(32'h0C, 32'hE590_4003, 1'b0);
        drain();
        chk("stall_fetch_cnt", 64'(fetch_cnt), 64'd21);

        // Simultaneous push and pop at occupancy one.
        rsp_ready = 1'b0;
        issue(32'h10, img[4], 1'b0);
        rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            issue(32'((i % 14) * 4), img[i % 14], 1'b0);
            chk("pp_valid", 64'(rsp_valid), 64'd1);
            chk("pp_ready", 64'(req_ready), 64'd1);
        end
        drain();
        chk("pp_fetch_cnt", 64'(fetch_cnt), 64'd32);
        chk("pp_err_cnt", 64'(err_cnt), 64'd3);

        // Reset with two buffered entries.
        rsp_ready = 1'b0;
        issue(32'h14, img[5], 1'b0);
        issue(32'h18, img[6], 1'b0);
        reset = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        chk("mid_rst_valid", 64'(rsp_valid), 64'd0);
        chk("mid_rst_ready", 64'(req_ready), 64'd1);
        chk("mid_rst_fetch_cnt", 64'(fetch_cnt), 64'd0);
        chk("mid_rst_err_cnt", 64'(err_cnt), 64'd0);
        rsp_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("no_stale_valid", 64'(rsp_valid), 64'd0);
        issue(32'h2C, 32'hE590_F000, 1'b0);
        drain();
        chk("post_rst_fetch_cnt", 64'(fetch_cnt), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
